rv32_dmem_ctrl: RTL and testbench

Data-memory controller between the core's data memory port and a single-port synchronous SRAM with byte enables. It accepts one load or store at a time, generates byte strobes and lane-replicated write data, and waits a configurable SRAM read latency. It returns lsb-aligned, sign- or zero-extended load data and pulses a one-cycle completion. The memory stage holds its request stable and stalls until that completion. Misaligned and out-of-range accesses complete with an error flag and never touch the SRAM.

---
 rtl/rv32_dmem_ctrl.sv | 147 ++++++++++++++
 tb/tb_rv32_dmem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_dmem_ctrl.sv
// rtl/rv32_dmem_ctrl.sv - data-memory controller between core data port and byte-enable SRAM
module rv32_dmem_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              req_done,
    output logic              req_error,
    output logic [31:0]       rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [ADDR_W-3:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic        op_write;
    logic [1:0]  op_off;
    logic [1:0]  op_size;
    logic        op_uns;

    logic        illegal;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign illegal = (req_size == 2'd3)
                   || (req_size == 2'd1 && req_addr[0])
                   || (req_size == 2'd2 && req_addr[1:0] != 2'd0)
                   || ((req_addr >> ADDR_W) != 32'd0);

    always_comb begin
        be_c = 4'b1111;
        wd_c = req_wdata;
        case (req_size)
            2'd0: begin
                be_c = 4'b0001 << req_addr[1:0];
                wd_c = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be_c = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_c = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = req_wdata;
            end
        endcase
    end

    // Offset and size are latched at acceptance so the capture does not depend on the held request.
    always_comb begin
        shifted  = sram_rdata >> {op_off, 3'b000};
        load_ext = shifted;
        case (op_size)
            2'd0:    load_ext = op_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_ext = op_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_write   <= 1'b0;
            op_off     <= '0;
            op_size    <= '0;
            op_uns     <= 1'b0;
            req_done   <= 1'b0;
            req_error  <= 1'b0;
            rdata      <= '0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_be    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            req_done  <= 1'b1;
                            req_error <= 1'b1;
                            rdata     <= '0;
                            state     <= S_RESP;
                        end else begin
                            sram_en    <= 1'b1;
                            sram_we    <= req_write;
                            sram_be    <= be_c;
                            sram_addr  <= req_addr[ADDR_W-1:2];
                            sram_wdata <= wd_c;
                            op_write   <= req_write;
                            op_off     <= req_addr[1:0];
                            op_size    <= req_size;
                            op_uns     <= req_unsigned;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    sram_en <= 1'b0;
                    sram_we <= 1'b0;
                    if (op_write) begin
                        req_done <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        cnt   <= 3'(READ_LATENCY - 1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        rdata    <= load_ext;
                        req_done <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    // The held request is deliberately not looked at here.
                    req_done  <= 1'b0;
                    req_error <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_dmem_ctrl.sv
// tb/tb_rv32_dmem_ctrl.sv - self-checking bench for rv32_dmem_ctrl with SRAM model and scoreboard
module tb_rv32_dmem_ctrl;

    localparam int ADDR_W = 16;
    localparam int RL     = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              req_done;
    logic              req_error;
    logic [31:0]       rdata;
    logic              sram_en;
    logic              sram_we;
    logic [3:0]        sram_be;
    logic [ADDR_W-3:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    rv32_dmem_ctrl #(.ADDR_W(ADDR_W), .READ_LATENCY(RL)) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_done     (req_done),
        .req_error    (req_error),
        .rdata        (rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_be      (sram_be),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: read data valid RL cycles after the enable cycle, garbage otherwise.
    logic [31:0] mem [0:255];
    logic [31:0] rd_pipe [RL];
    logic [RL-1:0] v_pipe;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_pipe <= '0;
        end else begin
            if (sram_en && sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
            rd_pipe[0] <= mem[sram_addr[7:0]];
            v_pipe[0]  <= sram_en && !sram_we;
            for (int i = 1; i < RL; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
                v_pipe[i]  <= v_pipe[i-1];
            end
        end
    end

    assign sram_rdata = v_pipe[RL-1] ? rd_pipe[RL-1] : 32'hA5A5_A5A5;

    int n_en;
    int n_wr;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            n_en <= 0;
            n_wr <= 0;
        end else if (sram_en) begin
            n_en <= n_en + 1;
            if (sram_we) n_wr <= n_wr + 1;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_rd;
    int          npass;
    int          ntot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input logic err,
                          input logic [31:0] ld_val, input logic [3:0] be, input logic [31:0] swd);
        exp_t e;
        int   lat;
        int   en0;
        logic got;
        e.err   = err;
        e.rdata = err ? 32'd0 : (wr ? last_rd : ld_val);
        last_rd = e.rdata;
        exp_q.push_back(e);
        lat = err ? 1 : (wr ? 2 : 2 + RL);
        en0 = n_en;
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wd;
        req_size     = sz;
        req_unsigned = uns;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1 && !err) begin
                chk("issue_en", 32'(sram_en), 32'd1);
                chk("issue_we", 32'(sram_we), 32'(wr));
                chk("issue_addr", 32'(sram_addr), 32'(addr[ADDR_W-1:2]));
                if (wr) begin
                    chk("issue_be", 32'(sram_be), 32'(be));
                    chk("issue_wdata", sram_wdata, swd);
                end
            end
            if (req_done) begin
                got = 1'b1;
                chk("latency", k, lat);
            end
        end
        e = exp_q.pop_front();
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("error", 32'(req_error), 32'(e.err));
            chk("rdata", rdata, e.rdata);
        end
        chk("sram_en_count", n_en - en0, err ? 0 : 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        npass = 0;
        ntot = 0;
        last_rd = 32'd0;
        resetn = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        #1;
        chk("rst_done", 32'(req_done), 32'd0);
        chk("rst_error", 32'(req_error), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_en", 32'(sram_en), 32'd0);
        chk("rst_we", 32'(sram_we), 32'd0);
        chk("rst_be", 32'(sram_be), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        // word store / load
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, 32'd0, 4'b1111, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'b0, 32'd0);
        do_req(1'b0, 32'h10, 32'd0, 2'd0, 1'b1, 1'b0, 32'h0000_00EF, 4'b0, 32'd0);
        // byte lanes
        do_req(1'b1, 32'h13, 32'h0000_0080, 2'd0, 1'b0, 1'b0, 32'd0, 4'b1000, 32'h8080_8080);
        do_req(1'b0, 32'h13, 32'd0, 2'd0, 1'b0, 1'b0, 32'hFFFF_FF80, 4'b0, 32'd0);
        do_req(1'b0, 32'h13, 32'd0, 2'd0, 1'b1, 1'b0, 32'h0000_0080, 4'b0, 32'd0);
        // half lanes
        do_req(1'b1, 32'h22, 32'h0000_8001, 2'd1, 1'b0, 1'b0, 32'd0, 4'b1100, 32'h8001_8001);
        do_req(1'b0, 32'h22, 32'd0, 2'd1, 1'b0, 1'b0, 32'hFFFF_8001, 4'b0, 32'd0);
        do_req(1'b0, 32'h22, 32'd0, 2'd1, 1'b1, 1'b0, 32'h0000_8001, 4'b0, 32'd0);
        // errors
        do_req(1'b0, 32'h02, 32'd0, 2'd2, 1'b0, 1'b1, 32'd0, 4'b0, 32'd0);
        do_req(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b0, 32'h80AD_BEEF, 4'b0, 32'd0);
        do_req(1'b0, 32'h01, 32'd0, 2'd1, 1'b0, 1'b1, 32'd0, 4'b0, 32'd0);
        do_req(1'b0, 32'h00, 32'd0, 2'd3, 1'b0, 1'b1, 32'd0, 4'b0, 32'd0);
        do_req(1'b0, 32'h0001_0000, 32'd0, 2'd2, 1'b0, 1'b1, 32'd0, 4'b0, 32'd0);
        do_req(1'b1, 32'h0001_0010, 32'h1111_1111, 2'd2, 1'b0, 1'b1, 32'd0, 4'b0, 32'd0);

        // held load through RESP, then a store on the very next cycle
        begin
            int en0;
            int wr0;
            en0 = n_en;
            wr0 = n_wr;
            do_req(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b0, 32'h80AD_BEEF, 4'b0, 32'd0);
            do_req(1'b1, 32'h30, 32'h1234_5678, 2'd2, 1'b0, 1'b0, 32'd0, 4'b1111, 32'h1234_5678);
            chk("b2b_reads", (n_en - en0) - (n_wr - wr0), 32'd1);
            chk("b2b_writes", n_wr - wr0, 32'd1);
        end
        do_req(1'b0, 32'h30, 32'd0, 2'd2, 1'b0, 1'b0, 32'h1234_5678, 4'b0, 32'd0);

        // reset asserted while a load is in WAIT
        begin
            int dones;
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr = 32'h10;
            req_size = 2'd2;
            req_unsigned = 1'b0;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            resetn = 1'b0;
            #1;
            chk("midrst_en", 32'(sram_en), 32'd0);
            chk("midrst_done", 32'(req_done), 32'd0);
            chk("midrst_rdata", rdata, 32'd0);
            req_valid = 1'b0;
            dones = 0;
            repeat (RL + 2) begin
                @(negedge clk);
                if (req_done) dones++;
            end
            chk("midrst_no_done", dones, 32'd0);
            @(posedge clk);
            #1 resetn = 1'b1;
            last_rd = 32'd0;
            @(posedge clk);
            #1;
        end
        do_req(1'b0, 32'h30, 32'd0, 2'd2, 1'b0, 1'b0, 32'h1234_5678, 4'b0, 32'd0);

        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
